// File: rtl/trigreg_bank.sv
// Triggered register bank: indexed writes per channel, round-robin
// delivery of armed channels on one output, hold or one-shot mode.
module trigreg_bank #(
    parameter int CH = 4,
    parameter int W = 8,
    parameter int HOLD = 1,
    parameter int LATENCY = 0,
    localparam int IW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [IW+W:0]     din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [IW+W-1:0]   dout_data
);

    localparam logic [IW:0] CH_L = (IW+1)'(CH);

    if (LATENCY != 0 && LATENCY != 1) begin : g_bad_latency
        $error("trigreg_bank: LATENCY must be 0 or 1");
    end

    logic [IW-1:0]        wr_idx;
    logic                 wr_flag;
    logic [W-1:0]         wr_data;
    logic                 wr_en;

    logic [CH-1:0]        flag_q, flag_d;
    logic [CH-1:0]        pend_q, pend_d;
    logic [CH-1:0][W-1:0] data_q, data_d;
    logic [CH-1:0]        elig;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        grant;
    logic                 any_elig;
    logic                 load;
    logic                 consume;

    logic                 ov_q, ov_d;
    logic [IW-1:0]        oidx_q, oidx_d;
    logic [W-1:0]         odata_q, odata_d;

    assign {wr_idx, wr_flag, wr_data} = din_data;
    assign wr_en = din_valid && ({1'b0, wr_idx} < CH_L);
    assign din_ready = 1'b1;

    assign elig = (HOLD != 0) ? flag_q : pend_q;
    assign any_elig = |elig;

    // Scan farthest-to-nearest from ptr so the nearest eligible wins.
    always_comb begin : arb
        int j;
        logic [IW-1:0] jj;
        grant = '0;
        j = 0;
        jj = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= CH) j = j - CH;
            jj = IW'(j);
            if (elig[jj]) grant = jj;
        end
    end

    assign load = any_elig && (!ov_q || dout_ready);
    assign consume = (LATENCY == 0) ? (any_elig && dout_ready) : load;

    // Consumption clears first so a same-cycle write wins.
    always_comb begin
        flag_d = flag_q;
        pend_d = pend_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (consume) begin
            pend_d[grant] = 1'b0;
            if (int'(grant) == CH - 1) ptr_d = '0;
            else ptr_d = grant + IW'(1);
        end
        if (wr_en) begin
            data_d[wr_idx] = wr_data;
            flag_d[wr_idx] = wr_flag;
            pend_d[wr_idx] = wr_flag;
        end
    end

    always_comb begin
        ov_d    = ov_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        if (load) begin
            ov_d    = 1'b1;
            oidx_d  = grant;
            odata_d = data_q[grant];
        end else if (dout_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
            pend_q <= '0;
            ptr_q  <= '0;
            ov_q   <= 1'b0;
        end else begin
            flag_q <= flag_d;
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            ov_q   <= ov_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q  <= data_d;
        oidx_q  <= oidx_d;
        odata_q <= odata_d;
    end

    assign dout_valid = (LATENCY == 0) ? any_elig : ov_q;
    assign dout_data  = (LATENCY == 0) ? {grant, data_q[grant]}
                                       : {oidx_q, odata_q};

endmodule

// File: tb/tb_trigreg_bank.sv
// Directed bench for trigreg_bank across hold/one-shot and both
// latencies, plus a CH=5 instance for out-of-range and wrap cases.
module tb_trigreg_bank;

    logic clk;
    logic rst;

    logic        dv  [4];
    logic        drd [4];
    logic [10:0] dd  [4];
    logic        rdy [4];
    logic        ov  [4];
    logic [9:0]  od  [4];

    logic        dv4, drd4, rdy4, ov4;
    logic [11:0] dd4;
    logic [10:0] od4;

    int vecs = 0;
    int miss = 0;

    trigreg_bank #(.CH(4), .W(8), .HOLD(0), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst),
        .din_valid(dv[0]), .din_ready(drd[0]), .din_data(dd[0]),
        .dout_valid(ov[0]), .dout_ready(rdy[0]), .dout_data(od[0])
    );
    trigreg_bank #(.CH(4), .W(8), .HOLD(1), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst),
        .din_valid(dv[1]), .din_ready(drd[1]), .din_data(dd[1]),
        .dout_valid(ov[1]), .dout_ready(rdy[1]), .dout_data(od[1])
    );
    trigreg_bank #(.CH(4), .W(8), .HOLD(0), .LATENCY(1)) u2 (
        .clk(clk), .rst(rst),
        .din_valid(dv[2]), .din_ready(drd[2]), .din_data(dd[2]),
        .dout_valid(ov[2]), .dout_ready(rdy[2]), .dout_data(od[2])
    );
    trigreg_bank #(.CH(4), .W(8), .HOLD(1), .LATENCY(1)) u3 (
        .clk(clk), .rst(rst),
        .din_valid(dv[3]), .din_ready(drd[3]), .din_data(dd[3]),
        .dout_valid(ov[3]), .dout_ready(rdy[3]), .dout_data(od[3])
    );
    trigreg_bank #(.CH(5), .W(8), .HOLD(0), .LATENCY(0)) u4 (
        .clk(clk), .rst(rst),
        .din_valid(dv4), .din_ready(drd4), .din_data(dd4),
        .dout_valid(ov4), .dout_ready(rdy4), .dout_data(od4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] pk(input logic [1:0] i,
                                       input logic f,
                                       input logic [7:0] d);
        return {i, f, d};
    endfunction

    function automatic logic [11:0] pk5(input logic [2:0] i,
                                        input logic f,
                                        input logic [7:0] d);
        return {i, f, d};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] md [4];
    logic       eov;
    logic [1:0] eidx, nidx, wch;
    logic [7:0] edat, wd;
    int         xfers;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dv[i] = 1'b0; dd[i] = '0; rdy[i] = 1'b0;
        end
        dv4 = 1'b0; dd4 = '0; rdy4 = 1'b0;

        // reset state
        nxt(); nxt(); nxt();
        mid();
        for (int i = 0; i < 4; i++) chk("reset_valid", ov[i], 0);
        chk("reset_valid4", ov4, 0);
        chk("din_ready_rst", drd[0], 1);

        // traffic, then 3-cycle reset
        nxt();
        rst = 1'b0;
        dv[0] = 1'b1; dd[0] = pk(0, 1, 8'h11);
        dv[1] = 1'b1; dd[1] = pk(0, 1, 8'h22);
        rdy[1] = 1'b1;
        nxt();
        dv[0] = 1'b0; dv[1] = 1'b0;
        mid();
        chk("pre_rst_v0", ov[0], 1);
        chk("pre_rst_d0", od[0], {2'd0, 8'h11});
        chk("pre_rst_v1", ov[1], 1);
        chk("pre_rst_d1", od[1], {2'd0, 8'h22});
        nxt();
        rst = 1'b1;
        nxt(); mid();
        chk("rst1_v0", ov[0], 0);
        chk("rst1_v1", ov[1], 0);
        nxt(); mid();
        chk("rst2_v0", ov[0], 0);
        chk("rst2_v1", ov[1], 0);
        nxt();
        rst = 1'b0;
        mid();
        chk("rst3_v0", ov[0], 0);
        chk("rst3_v1", ov[1], 0);
        nxt();
        rdy[0] = 1'b1;
        mid();
        chk("post_rst_v0", ov[0], 0);
        chk("post_rst_v1", ov[1], 0);
        nxt();
        rdy[0] = 1'b0; rdy[1] = 1'b0;

        // round robin, one-shot, ready held low while arming
        dv[0] = 1'b1; dd[0] = pk(0, 1, 8'h10);
        nxt(); dd[0] = pk(1, 1, 8'h11);
        nxt(); dd[0] = pk(3, 1, 8'h13);
        nxt(); dv[0] = 1'b0;
        mid();
        chk("rr_wait_v", ov[0], 1);
        chk("rr_wait_d", od[0], {2'd0, 8'h10});
        nxt(); mid();
        chk("rr_stall_d", od[0], {2'd0, 8'h10});
        nxt();
        rdy[0] = 1'b1;
        mid();
        chk("rr_x0_d", od[0], {2'd0, 8'h10});
        nxt(); mid();
        chk("rr_x1_v", ov[0], 1);
        chk("rr_x1_d", od[0], {2'd1, 8'h11});
        nxt(); mid();
        chk("rr_x3_v", ov[0], 1);
        chk("rr_x3_d", od[0], {2'd3, 8'h13});
        nxt(); mid();
        chk("rr_done_v", ov[0], 0);
        chk("rr_ptr", u0.ptr_q, 0);

        // one-shot single transfer
        nxt();
        dv[0] = 1'b1; dd[0] = pk(2, 1, 8'hA5);
        nxt();
        dv[0] = 1'b0;
        mid();
        chk("os_v", ov[0], 1);
        chk("os_d", od[0], {2'd2, 8'hA5});
        nxt(); mid();
        chk("os_once", ov[0], 0);
        nxt(); mid();
        chk("os_idle", ov[0], 0);

        // hold mode: repeated payload, then disarm
        rdy[1] = 1'b1;
        dv[1] = 1'b1; dd[1] = pk(1, 1, 8'h3C);
        nxt();
        dv[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("hold_v", ov[1], 1);
            chk("hold_d", od[1], {2'd1, 8'h3C});
            nxt();
        end
        dv[1] = 1'b1; dd[1] = pk(1, 0, 8'h00);
        nxt();
        dv[1] = 1'b0;
        mid();
        chk("hold_disarm", ov[1], 0);

        // collision at load time, latency 1
        nxt();
        dv[2] = 1'b1; dd[2] = pk(2, 1, 8'h55);
        nxt();
        dd[2] = pk(2, 1, 8'h77);
        mid();
        chk("col_lat_v", ov[2], 0);
        nxt();
        dv[2] = 1'b0;
        mid();
        chk("col_v0", ov[2], 1);
        chk("col_d0", od[2], {2'd2, 8'h55});
        nxt(); mid();
        chk("col_snap", od[2], {2'd2, 8'h55});
        nxt();
        rdy[2] = 1'b1;
        mid();
        chk("col_x0", od[2], {2'd2, 8'h55});
        nxt(); mid();
        chk("col_v1", ov[2], 1);
        chk("col_d1", od[2], {2'd2, 8'h77});
        nxt(); mid();
        chk("col_end", ov[2], 0);

        // CH=5: out-of-range drop and wrap of the pointer
        nxt();
        rdy4 = 1'b1;
        dv4 = 1'b1; dd4 = pk5(7, 1, 8'h99);
        nxt(); dd4 = pk5(5, 1, 8'h98);
        nxt(); dv4 = 1'b0;
        mid();
        chk("oor_v0", ov4, 0);
        nxt(); mid();
        chk("oor_v1", ov4, 0);
        nxt();
        dv4 = 1'b1; dd4 = pk5(4, 1, 8'h44);
        nxt();
        dd4 = pk5(0, 1, 8'h40);
        mid();
        chk("wrap_d4", od4, {3'd4, 8'h44});
        nxt();
        dv4 = 1'b0;
        mid();
        chk("wrap_v0", ov4, 1);
        chk("wrap_d0", od4, {3'd0, 8'h40});
        nxt(); mid();
        chk("wrap_end", ov4, 0);
        chk("wrap_ptr", u4.ptr_q, 1);

        // backpressure, latency 1, hold, two channels armed
        nxt();
        dv[3] = 1'b1; dd[3] = pk(0, 1, 8'h40);
        nxt();
        dd[3] = pk(2, 1, 8'h42);
        nxt();
        dv[3] = 1'b0;
        mid();
        chk("bp_first_v", ov[3], 1);
        chk("bp_first_d", od[3], {2'd0, 8'h40});
        md[0] = 8'h40; md[1] = 8'h00;
        md[2] = 8'h42; md[3] = 8'h00;
        eov = 1'b1; eidx = 2'd0; edat = 8'h40; nidx = 2'd2;
        xfers = 0;
        wch = 2'd0; wd = 8'h00;
        for (int c = 0; c < 200; c++) begin
            nxt();
            rdy[3] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                wch = $urandom_range(0, 1) != 0 ? 2'd2 : 2'd0;
                wd = 8'($urandom_range(0, 255));
                dv[3] = 1'b1;
                dd[3] = pk(wch, 1, wd);
            end else begin
                dv[3] = 1'b0;
            end
            mid();
            chk("bp_v", ov[3], eov);
            chk("bp_d", od[3], {eidx, edat});
            if (rdy[3]) xfers++;
            if (!eov || rdy[3]) begin
                eidx = nidx;
                edat = md[nidx];
                nidx = (nidx == 2'd0) ? 2'd2 : 2'd0;
                eov = 1'b1;
            end
            if (dv[3]) md[wch] = wd;
        end
        nxt();
        dv[3] = 1'b0; rdy[3] = 1'b0;
        mid();
        chk("bp_some_xfers", 32'(xfers > 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miss);
        $finish;
    end

endmodule
